// File: rtl/rv32i_types.sv
// Shared rename/register-file constants for the rv32i OoO core.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rv32i_types;

  localparam int PHYS_REG_BITS   = 6;
  localparam int ARCH_REG_BITS   = 5;
  localparam int NUM_PHYS_REGS   = 2 ** PHYS_REG_BITS;
  // Physical registers not held by a committed architectural mapping.
  localparam int FREE_LIST_DEPTH = NUM_PHYS_REGS - 32;

endpackage

// File: rtl/free_list.sv
// Circular queue of free physical register indices; RRAT frees at commit, rename allocates.
// Latency: deq_pd is a zero-latency read of head; an enqueued entry becomes visible next cycle.
// Backpressure: rename stalls on empty; an enqueue at full without a dequeue is dropped and flagged.
module free_list #(
  parameter int PHYS_REG_BITS = rv32i_types::PHYS_REG_BITS,
  parameter int FL_DEPTH      = rv32i_types::FREE_LIST_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enqueue,
  input  logic [PHYS_REG_BITS-1:0]   enq_pd,
  input  logic                       dequeue,
  output logic [PHYS_REG_BITS-1:0]   deq_pd,
  input  logic                       flush,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(FL_DEPTH):0]  count,
  output logic                       overflow
);

  localparam int IDX_W = $clog2(FL_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PHYS_REG_BITS-1:0] entry [FL_DEPTH];
  logic [PTR_W-1:0]         head, tail;
  logic [PTR_W-1:0]         head_next, tail_next;
  logic                     deq_acc, enq_acc;

  assign empty  = (head == tail);
  assign full   = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
  assign count  = tail - head;
  assign deq_pd = entry[head[IDX_W-1:0]];

  // Accept/drop decisions and next pointers; flush rewinds head to one lap behind tail.
  always_comb begin
    deq_acc   = dequeue && !empty && !flush;
    enq_acc   = enqueue && (!full || deq_acc);
    tail_next = tail + PTR_W'(enq_acc);
    if (flush) begin
      head_next = {~tail_next[IDX_W], tail_next[IDX_W-1:0]};
    end else begin
      head_next = head + PTR_W'(deq_acc);
    end
  end

  // Pointer and sticky overflow state; reset leaves the queue full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= PTR_W'(FL_DEPTH);
      overflow <= 1'b0;
    end else begin
      head <= head_next;
      tail <= tail_next;
      if (enqueue && !enq_acc) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry storage; reset preloads the registers not covered by the initial architectural mapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry[i] <= PHYS_REG_BITS'(FL_DEPTH + i);
      end
    end else if (enq_acc) begin
      entry[tail[IDX_W-1:0]] <= enq_pd;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list.
// Latency: inputs driven 1ns after posedge, outputs sampled before the next posedge.
// Backpressure: exercises empty/full boundaries, flush restore and asynchronous reset.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       enqueue;
  logic [5:0] enq_pd;
  logic       dequeue;
  logic [5:0] deq_pd;
  logic       flush;
  logic       empty;
  logic       full;
  logic [5:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  free_list dut (
    .clk      (clk),
    .rst      (rst),
    .enqueue  (enqueue),
    .enq_pd   (enq_pd),
    .dequeue  (dequeue),
    .deq_pd   (deq_pd),
    .flush    (flush),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs may be changed on return.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enqueue = 1'b0;
    dequeue = 1'b0;
    flush   = 1'b0;
    enq_pd  = 6'd0;
  endtask

  // Reset pulse between clock edges (called 1ns after a posedge).
  task automatic pulse_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_deq_pd"},   int'(deq_pd),   32);
    chk({tag, "_full"},     int'(full),     1);
    chk({tag, "_empty"},    int'(empty),    0);
    chk({tag, "_count"},    int'(count),    32);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  // Structural invariants observed every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(enqueue && enq_pd == 6'd0)) else $error("enqueue of physical register 0");
      assert (count <= 6'd32) else $error("count above depth: %0d", count);
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    #12;
    rst = 1'b0;
    step();

    // Reset state
    chk_reset_state("reset");

    // Drain: 32..63 in order
    for (int i = 0; i < 32; i++) begin
      dequeue = 1'b1;
      #1;
      chk($sformatf("drain_%0d", i), int'(deq_pd), 32 + i);
      step();
    end
    idle();
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);

    // Dequeue on empty is ignored
    dequeue = 1'b1;
    step();
    idle();
    chk("deq_empty_count", int'(count), 0);
    chk("deq_empty_empty", int'(empty), 1);
    chk("deq_empty_full",  int'(full),  0);

    // Enqueue+dequeue collision while empty: only enqueue lands, no bypass
    enqueue = 1'b1;
    enq_pd  = 6'd5;
    dequeue = 1'b1;
    #1;
    chk("collide_no_bypass_empty", int'(empty), 1);
    step();
    idle();
    chk("collide_count",  int'(count),  1);
    chk("collide_deq_pd", int'(deq_pd), 5);
    chk("collide_empty",  int'(empty),  0);

    // Flush restore
    pulse_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      dequeue = 1'b1;
      #1;
      chk($sformatf("pre_flush_deq_%0d", i), int'(deq_pd), 32 + i);
      step();
    end
    idle();
    enqueue = 1'b1;
    enq_pd  = 6'd7;
    step();
    idle();
    chk("pre_flush_count", int'(count), 30);
    flush   = 1'b1;
    dequeue = 1'b1;
    step();
    idle();
    chk("flush_count", int'(count), 32);
    chk("flush_full",  int'(full),  1);
    for (int i = 0; i < 32; i++) begin
      dequeue = 1'b1;
      #1;
      chk($sformatf("post_flush_deq_%0d", i), int'(deq_pd), (i < 31) ? 33 + i : 7);
      step();
    end
    idle();
    chk("post_flush_empty", int'(empty), 1);

    // Refill by flush, then full boundary
    flush = 1'b1;
    step();
    idle();
    chk("refill_full", int'(full), 1);
    enqueue = 1'b1;
    enq_pd  = 6'd9;
    dequeue = 1'b1;
    step();
    idle();
    chk("full_both_count",    int'(count),    32);
    chk("full_both_overflow", int'(overflow), 0);
    chk("full_both_full",     int'(full),     1);
    enqueue = 1'b1;
    enq_pd  = 6'd9;
    step();
    idle();
    chk("full_drop_overflow", int'(overflow), 1);
    chk("full_drop_count",    int'(count),    32);
    step();
    step();
    step();
    chk("overflow_sticky", int'(overflow), 1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 10; i++) begin
      dequeue = 1'b1;
      step();
    end
    idle();
    chk("pre_areset_count", int'(count), 22);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_state("areset");
    #1;
    rst = 1'b0;
    step();
    chk("after_areset_deq_pd", int'(deq_pd), 32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
